// File: rtl/bus_initiator.sv
// Single-outstanding command initiator for the peripheral req/gnt/rvalid bus.
// Takes one command at a time, runs it on the bus and returns rdata/err with grant and rvalid timeouts.
module bus_initiator #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [3:0]            cmd_be_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  stray_rvalid_o
);

  // state | meaning
  // IDLE  | ready for a command
  // REQ   | request on the bus, waiting for grant
  // WAIT  | granted, waiting for rvalid
  // RESP  | response held until consumed
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  logic [1:0]            state;
  logic [TW-1:0]         timer;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  stray_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      timer   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      // Any rvalid outside WAIT (including one racing the grant) is a stray.
      if (data_rvalid_i && (state != S_WAIT)) stray_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            be_q    <= cmd_be_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            timer   <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            timer <= '0;
            state <= S_WAIT;
          end else if (timer == T_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= S_RESP;
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            rdata_q <= we_q ? 32'h0 : data_rdata_i;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (timer == T_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= S_RESP;
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so ready stays low until reset is released.
  assign cmd_ready_o    = (state == S_IDLE) && !rst_i;
  assign rsp_valid_o    = (state == S_RESP);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign data_req_o     = (state == S_REQ);
  assign data_we_o      = we_q;
  assign data_be_o      = be_q;
  assign data_addr_o    = addr_q;
  assign data_wdata_o   = wdata_q;
  assign stray_rvalid_o = stray_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a vector table of bus transactions plus
// hand sequences for backpressure, late rvalid, reset in WAIT and gnt/rvalid collision.
module tb_bus_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_be_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [11:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        stray_rvalid_o;

  bus_initiator #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_be_i(cmd_be_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .stray_rvalid_o(stray_rvalid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;   // grant on this 0-based req cycle; >=16 means never
    int          rv_dly;    // rvalid on this 1-based WAIT cycle; 0 means never
    logic [31:0] bus_rdata;
    int          exp_req;
    int          exp_rsp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_stray = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge where rsp_valid_o is first seen.
  task automatic run_txn(input vec_t v);
    int  req_cnt = 0, wait_cnt = 0, rsp_cyc = 0, bad = 0;
    bit  granted = 0, done = 0;
    cmd_we_i = v.we; cmd_be_i = v.be; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata;
    cmd_valid_i = 1'b1;
    chk("cmd_ready_idle", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (c > 1) @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
      if (data_req_o) begin
        req_cnt++;
        if (data_we_o !== v.we || data_be_o !== v.be || data_addr_o !== v.addr ||
            data_wdata_o !== v.wdata) bad++;
        if (req_cnt - 1 == v.gnt_dly) begin
          data_gnt_i = 1'b1; granted = 1;
        end
      end else if (granted && !rsp_valid_o) begin
        wait_cnt++;
        if (wait_cnt == v.rv_dly) begin
          data_rvalid_i = 1'b1; data_rdata_i = v.bus_rdata;
        end
      end
      if (rsp_valid_o) begin
        rsp_cyc = c; done = 1;
      end
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    chk("rsp_within_budget", done, 1);
    chk("bus_fields_stable", bad, 0);
    chk("req_cycles", req_cnt, v.exp_req);
    chk("rsp_latency", rsp_cyc, v.exp_rsp_cyc);
    chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
    chk("rsp_err", rsp_err_o, v.exp_err);
    chk("stray_flag", stray_rvalid_o, exp_stray);
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid_o, 0);
    chk("cmd_ready_after_hs", cmd_ready_o, 1);
    chk("req_after_hs", data_req_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'hF, 12'h004, 32'h0,         0,  1, 32'h0000_A5A5, 1,  3,  32'h0000_A5A5, 1'b0};
    vecs[1] = '{1'b1, 4'hF, 12'h000, 32'h0000_00FF, 3,  1, 32'hDEAD_BEEF, 4,  6,  32'h0,         1'b0};
    vecs[2] = '{1'b0, 4'hF, 12'h008, 32'h0,         99, 1, 32'h1111_1111, 16, 17, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 4'hF, 12'h00C, 32'h0,         0,  0, 32'h2222_2222, 1,  18, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 4'h3, 12'hFFF, 32'h0,         1,  3, 32'h1234_5678, 2,  6,  32'h1234_5678, 1'b0};
    vecs[5] = '{1'b0, 4'h1, 12'h100, 32'h0,         0,  16, 32'hCAFE_0001, 1, 18, 32'hCAFE_0001, 1'b0};
    vecs[6] = '{1'b1, 4'hC, 12'h200, 32'hA5A5_5A5A, 15, 1, 32'h3333_3333, 16, 18, 32'h0,         1'b0};

    rst_i = 1'b1; cmd_valid_i = 0; cmd_we_i = 0; cmd_be_i = 0; cmd_addr_i = 0;
    cmd_wdata_i = 0; rsp_ready_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    #12;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_req", data_req_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_stray", stray_rvalid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_cmd_ready", cmd_ready_o, 1);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
      handshake();
      @(negedge clk_i);
      chk("bus_quiet_after", data_req_o, 0);
    end

    // Response backpressure with a second command already waiting.
    run_txn('{1'b0, 4'hF, 12'h010, 32'h0, 0, 1, 32'h0BAD_F00D, 1, 3, 32'h0BAD_F00D, 1'b0});
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 12'h020; cmd_be_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", cmd_ready_o, 0);
      chk("bp_rsp_valid", rsp_valid_o, 1);
      chk("bp_rsp_rdata", rsp_rdata_o, 32'h0BAD_F00D);
      chk("bp_no_req", data_req_o, 0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("bp_idle_cmd_ready", cmd_ready_o, 1);
    chk("bp_no_req_hs_cycle", data_req_o, 0);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("bp_second_req", data_req_o, 1);
    chk("bp_second_addr", data_addr_o, 12'h020);
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_0077;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    chk("bp_second_rdata", rsp_rdata_o, 32'h0000_0077);
    handshake();

    // Rvalid timeout, then the late rvalid arrives while idle.
    run_txn('{1'b0, 4'hF, 12'h040, 32'h0, 0, 0, 32'h0, 1, 18, 32'h0, 1'b1});
    handshake();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    chk("late_stray_set", stray_rvalid_o, 1);
    chk("late_still_idle", cmd_ready_o, 1);
    chk("late_no_rsp", rsp_valid_o, 0);
    exp_stray = 1'b1;
    run_txn(vecs[0]);
    handshake();

    // Reset asserted while in WAIT.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 12'h030;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    chk("wait_req_low", data_req_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_req", data_req_o, 0);
    chk("arst_rsp_valid", rsp_valid_o, 0);
    chk("arst_stray", stray_rvalid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("arst_release_ready", cmd_ready_o, 1);
    chk("arst_release_no_rsp", rsp_valid_o, 0);
    @(negedge clk_i);
    exp_stray = 1'b0;
    run_txn(vecs[4]);
    handshake();

    // Grant and rvalid together in the REQ cycle: grant wins, stray is flagged.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 12'h050;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h9999_9999;
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    chk("collide_stray", stray_rvalid_o, 1);
    chk("collide_in_wait", {data_req_o, rsp_valid_o}, 2'b00);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_0ABC;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    chk("collide_rsp_valid", rsp_valid_o, 1);
    chk("collide_rdata", rsp_rdata_o, 32'h0000_0ABC);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
